// File: rtl/dual_rate_counter.sv
// dual_rate_counter
//
// Pair of event counters sharing one enable and a select line. With Slt low,
// every enabled clock advances the fast counter Output0. With Slt high, enabled
// clocks feed a prescaler, and the slow counter Output1 advances once every DIV
// such clocks. The block is used as a simple cycle/event statistics source in
// the pre-CPU test infrastructure.
//
// Parameters:
//   WIDTH - width of both counters; each wraps modulo 2^WIDTH
//   DIV   - enabled Slt=1 clocks per Output1 increment (2..256)
//
// Ports:
//   Clk     - clock; all state changes on its rising edge
//   Reset   - synchronous active-low reset; clears both counters and the prescaler
//   Slt     - counter select: 0 = Output0, 1 = Output1 (through the prescaler)
//   En      - count enable; nothing changes while low
//   Output0 - fast counter, registered
//   Output1 - slow (divided) counter, registered

module dual_rate_counter #(
  parameter int WIDTH = 64,
  parameter int DIV   = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Slt,
  input  logic             En,
  output logic [WIDTH-1:0] Output0,
  output logic [WIDTH-1:0] Output1
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [PW-1:0] pre;

  // Priority is Reset, then En, then Slt. At most one counter moves per edge.
  // The prescaler is only touched by reset or by an enabled Slt=1 edge. Partial
  // progress therefore survives periods spent on the fast counter or idle.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      Output0 <= '0;
      Output1 <= '0;
      pre     <= '0;
    end else if (En) begin
      if (!Slt) begin
        Output0 <= Output0 + WIDTH'(1);
      end else if (pre == PRE_LAST) begin
        Output1 <= Output1 + WIDTH'(1);
        pre     <= '0;
      end else begin
        pre <= pre + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_dual_rate_counter.sv
// tb_dual_rate_counter
//
// Table of {Reset, En, Slt, expected Output0, expected Output1} records is
// applied to a WIDTH=64/DIV=4 instance. A second WIDTH=8/DIV=2 instance covers
// wrap-around and the smallest prescaler with a hand-written sequence.

module tb_dual_rate_counter;

  typedef struct {
    string       name;
    logic        rst;
    logic        en;
    logic        slt;
    logic [63:0] exp0;
    logic [63:0] exp1;
  } vec_t;

  logic        clk;
  logic        reset, en, slt;
  logic [63:0] output0, output1;
  logic        wReset, wEn, wSlt;
  logic [7:0]  wOutput0, wOutput1;

  int checkCount;
  int failCount;
  vec_t vecs[$];

  dual_rate_counter #(.WIDTH(64), .DIV(4)) dut (
    .Clk(clk), .Reset(reset), .Slt(slt), .En(en),
    .Output0(output0), .Output1(output1)
  );

  dual_rate_counter #(.WIDTH(8), .DIV(2)) dutWrap (
    .Clk(clk), .Reset(wReset), .Slt(wSlt), .En(wEn),
    .Output0(wOutput0), .Output1(wOutput1)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic addVec(input string name, input logic r, input logic e,
                        input logic s, input logic [63:0] x0,
                        input logic [63:0] x1);
    vec_t v;
    v.name = name; v.rst = r; v.en = e; v.slt = s; v.exp0 = x0; v.exp1 = x1;
    vecs.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 unit after rise.
  task automatic applyStimulus(input logic r, input logic e, input logic s);
    @(negedge clk);
    reset = r; en = e; slt = s;
    @(posedge clk);
    #1;
  endtask

  task automatic stepWrap(input logic r, input logic e, input logic s);
    @(negedge clk);
    wReset = r; wEn = e; wSlt = s;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] exp);
    checkCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  initial begin
    checkCount = 0;
    failCount  = 0;
    reset = 1'b0; en = 1'b0; slt = 1'b0;
    wReset = 1'b0; wEn = 1'b0; wSlt = 1'b0;

    // Reset hold: reset beats En, Slt toggling.
    for (int i = 0; i < 5; i++) addVec("resetHold", 0, 1, 1'(i % 2), 0, 0);
    // Fast count 1..10, then hold with En low and Slt toggling.
    for (int i = 0; i < 10; i++) addVec("fastCount", 1, 1, 0, 64'(i + 1), 0);
    for (int i = 0; i < 5; i++) addVec("fastHold", 1, 0, 1'(i % 2), 10, 0);
    // Divided count from reset: Output1 = edge/4.
    addVec("divReset", 0, 1, 1, 0, 0);
    for (int i = 0; i < 9; i++) addVec("divCount", 1, 1, 1, 0, 64'((i + 1) / 4));
    // Prescaler retention across an idle edge and two fast edges.
    addVec("retReset", 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) addVec("retSlow", 1, 1, 1, 0, 0);
    addVec("retIdle", 1, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) addVec("retFast", 1, 1, 0, 64'(i + 1), 0);
    addVec("retResume", 1, 1, 1, 2, 1);
    // Mid-operation reset: build Output0=7, Output1=3, pre=2 first.
    addVec("midReset0", 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) addVec("midFast", 1, 1, 0, 64'(i + 1), 0);
    for (int i = 0; i < 14; i++) addVec("midSlow", 1, 1, 1, 7, 64'((i + 1) / 4));
    addVec("midReset", 0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) addVec("midAfter", 1, 1, 1, 0, (i == 3) ? 64'd1 : 64'd0);

    foreach (vecs[k]) begin
      applyStimulus(vecs[k].rst, vecs[k].en, vecs[k].slt);
      checkOutput({vecs[k].name, ".out0"}, output0, vecs[k].exp0);
      checkOutput({vecs[k].name, ".out1"}, output1, vecs[k].exp1);
    end

    // Wrap-around on the 8-bit instance.
    stepWrap(0, 1, 0);
    checkOutput("wrapReset.out0", {56'd0, wOutput0}, 0);
    checkOutput("wrapReset.out1", {56'd0, wOutput1}, 0);
    for (int n = 1; n <= 257; n++) begin
      stepWrap(1, 1, 0);
      if (n == 255) checkOutput("wrap255", {56'd0, wOutput0}, 255);
      if (n == 256) checkOutput("wrap256", {56'd0, wOutput0}, 0);
      if (n == 257) checkOutput("wrap257", {56'd0, wOutput0}, 1);
    end
    checkOutput("wrapOut1", {56'd0, wOutput1}, 0);

    // Smallest prescaler: DIV=2 gives Output1 on every second slow edge.
    stepWrap(1, 1, 1);
    checkOutput("div2a.out1", {56'd0, wOutput1}, 0);
    stepWrap(1, 1, 1);
    checkOutput("div2b.out1", {56'd0, wOutput1}, 1);
    checkOutput("div2b.out0", {56'd0, wOutput0}, 1);
    stepWrap(1, 0, 1);
    stepWrap(1, 1, 1);
    checkOutput("div2c.out1", {56'd0, wOutput1}, 1);
    stepWrap(1, 1, 1);
    checkOutput("div2d.out1", {56'd0, wOutput1}, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
